// File: rtl/seq_add_slices_pkg.sv
// Shared definitions for the sequential slice adder: slice width, FSM
// state encoding and the index-counter width helper.
package seq_add_slices_pkg;

    localparam int SLICE_W = 6;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of the slice index counter: clog2(words), never below 1 bit.
    function automatic int idx_width(input int words);
        return (words <= 1) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/seq_add_slices_if.sv
// Request/result bundle for seq_add_slices.
// With SEQ_ADD_SLICES_SUB_EN defined, a Sub request bit is added.
interface seq_add_slices_if
    import seq_add_slices_pkg::*;
#(
    parameter int WORDS = 2
);
    localparam int W = SLICE_W * WORDS;

    logic         start;
`ifdef SEQ_ADD_SLICES_SUB_EN
    logic         Sub;
`endif
    logic [W-1:0] Ain;
    logic [W-1:0] Bin;
    logic         Ci;
    logic         busy;
    logic         done;
    logic [W-1:0] Sout;
    logic         Co;
    logic         Ovf;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start,
`ifdef SEQ_ADD_SLICES_SUB_EN
        output Sub,
`endif
        output Ain, Bin, Ci,
        input  busy, done, Sout, Co, Ovf
    );

    // Adder side.
    modport slave (
        input  start,
`ifdef SEQ_ADD_SLICES_SUB_EN
        input  Sub,
`endif
        input  Ain, Bin, Ci,
        output busy, done, Sout, Co, Ovf
    );

endinterface

// File: rtl/seq_add_slices_add6_slice.sv
// Combinational 6-bit ripple-carry adder built from per-bit full adders.
// C4 is the carry into the top bit, used upstream for overflow detection.
module add6_slice
    import seq_add_slices_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               Cout,
    output logic               C4
);

    logic [SLICE_W:0] carry;

    assign carry[0] = Cin;

    // One full adder per bit, rippling the carry upward.
    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
            assign S[gi]         = A[gi] ^ B[gi] ^ carry[gi];
            assign carry[gi + 1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
        end
    endgenerate

    assign C4   = carry[SLICE_W-1];
    assign Cout = carry[SLICE_W];

endmodule

// File: rtl/seq_add_slices.sv
// Multi-cycle wide adder: adds two (6*WORDS)-bit operands one 6-bit slice
// per clock, LSB slice first, through a single add6_slice, with the carry
// between slices held in a register.
// Optional build macro: SEQ_ADD_SLICES_SUB_EN adds a Sub request bit that
// turns the operation into Ain - Bin (Bin inverted, carry-in forced to 1).
module seq_add_slices
    import seq_add_slices_pkg::*;
#(
    parameter int WORDS = 2
)(
    input  logic                clk,
    input  logic                rst,
    seq_add_slices_if.slave     bus
);

    localparam int                W        = SLICE_W * WORDS;
    localparam int                IDX_W    = idx_width(WORDS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state_reg, state_next;
    logic [W-1:0]       a_reg, b_reg;
    logic [W-1:0]       psum_reg, psum_next;
    logic [W-1:0]       sout_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic               co_reg, ovf_reg, done_reg;

    logic               accept, last_slice;
    logic [W-1:0]       b_latch;
    logic               c0_latch;

    logic [SLICE_W-1:0] cur_a, cur_b, slice_sum;
    logic               slice_cout, slice_c4;

    // Operand B and carry-in as they are captured on an accepted start.
`ifdef SEQ_ADD_SLICES_SUB_EN
    assign b_latch  = bus.Sub ? ~bus.Bin : bus.Bin;
    assign c0_latch = bus.Sub | bus.Ci;
`else
    assign b_latch  = bus.Bin;
    assign c0_latch = bus.Ci;
`endif

    // Select the operand slice addressed by the index counter.
    always_comb begin
        cur_a = '0;
        cur_b = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_a = a_reg[i*SLICE_W +: SLICE_W];
                cur_b = b_reg[i*SLICE_W +: SLICE_W];
            end
        end
    end

    add6_slice u_slice (
        .A    (cur_a),
        .B    (cur_b),
        .Cin  (carry_reg),
        .S    (slice_sum),
        .Cout (slice_cout),
        .C4   (slice_c4)
    );

    // Partial sum with the current slice result merged into its position.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_psum
            assign psum_next[gi*SLICE_W +: SLICE_W] =
                (idx_reg == IDX_W'(gi)) ? slice_sum : psum_reg[gi*SLICE_W +: SLICE_W];
        end
    endgenerate

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next state: accept start only when idle, finish on the last slice.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        last_slice = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (idx_reg == LAST_IDX) begin
                    last_slice = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture operands, step one slice per clock, publish result.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            psum_reg  <= '0;
            sout_reg  <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            co_reg    <= 1'b0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= last_slice;
            if (accept) begin
                a_reg     <= bus.Ain;
                b_reg     <= b_latch;
                carry_reg <= c0_latch;
                psum_reg  <= '0;
                idx_reg   <= '0;
            end else if (state_reg == RUN) begin
                psum_reg  <= psum_next;
                carry_reg <= slice_cout;
                idx_reg   <= idx_reg + 1'b1;
                if (last_slice) begin
                    sout_reg <= psum_next;
                    co_reg   <= slice_cout;
                    ovf_reg  <= slice_c4 ^ slice_cout;
                    idx_reg  <= '0;
                end
            end
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = done_reg;
    assign bus.Sout = sout_reg;
    assign bus.Co   = co_reg;
    assign bus.Ovf  = ovf_reg;

endmodule

// File: tb/tb_seq_add_slices.sv
// Bench for seq_add_slices (WORDS=2, 12-bit operands). The driver issues
// directed operations and queues the hand-computed results; a monitor pops
// and compares whenever done is seen.
module tb_seq_add_slices;

    localparam int WORDS = 2;

    typedef struct {
        logic [11:0] s;
        logic        co;
        logic        ovf;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    seq_add_slices_if #(.WORDS(WORDS)) bus ();

    seq_add_slices #(.WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".Sout"}, 32'(bus.Sout), 32'(e.s));
                chk({e.name, ".Co"},   32'(bus.Co),   32'(e.co));
                chk({e.name, ".Ovf"},  32'(bus.Ovf),  32'(e.ovf));
                $display("txn %s: Sout=%03h Co=%0b Ovf=%0b", e.name, bus.Sout, bus.Co, bus.Ovf);
            end
        end
    end

    // One operation: start before the next edge, scramble operands while
    // busy, then wait (bounded) for done and check the latency.
    task automatic run_op(input string name, input logic [11:0] a, input logic [11:0] b,
                          input logic ci, input logic sub,
                          input logic [11:0] es, input logic eco, input logic eovf);
        int lat;
        exp_t e;
        bus.Ain = a;
        bus.Bin = b;
        bus.Ci  = ci;
`ifdef SEQ_ADD_SLICES_SUB_EN
        bus.Sub = sub;
`endif
        bus.start = 1'b1;
        e.s = es; e.co = eco; e.ovf = eovf; e.name = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.Ain   = ~a;
        bus.Bin   = ~b;
        bus.Ci    = ~ci;
`ifdef SEQ_ADD_SLICES_SUB_EN
        bus.Sub   = ~sub;
`endif
        chk({name, ".busy"}, 32'(bus.busy), 32'd1);
        lat = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
        chk({name, ".latency"}, 32'(lat), 32'(WORDS));
    endtask

    // Vectors for continuous-start test: only cycles 0, 3, 6 are accepted.
    logic [11:0] cs_a  [9] = '{12'h123, 12'hFFF, 12'hAAA, 12'h0FF, 12'h777, 12'h001,
                               12'h900, 12'hFFF, 12'h555};
    logic [11:0] cs_b  [9] = '{12'h456, 12'hFFF, 12'h555, 12'h0F1, 12'h777, 12'h002,
                               12'h900, 12'h001, 12'h333};
    logic        cs_ci [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] cs_s  [9] = '{12'h579, 12'h000, 12'h000, 12'h1F1, 12'h000, 12'h000,
                               12'h200, 12'h000, 12'h000};
    logic        cs_co [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        cs_ov [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.start = 1'b0;
        bus.Ain   = '0;
        bus.Bin   = '0;
        bus.Ci    = 1'b0;
`ifdef SEQ_ADD_SLICES_SUB_EN
        bus.Sub   = 1'b0;
`endif
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.Sout", 32'(bus.Sout), 32'd0);
        chk("reset.Co",   32'(bus.Co),   32'd0);
        chk("reset.Ovf",  32'(bus.Ovf),  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Carry crossing slices, wrap-around, carry-in, signed overflow.
        run_op("carry_cross", 12'h03F, 12'h001, 1'b0, 1'b0, 12'h040, 1'b0, 1'b0);
        run_op("wrap",        12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0);
        run_op("ci_only",     12'h000, 12'h000, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0);
        run_op("pos_ovf",     12'h7FF, 12'h001, 1'b0, 1'b0, 12'h800, 1'b0, 1'b1);
        run_op("neg_ovf",     12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1);

        // Result values must hold after the done pulse.
        repeat (2) @(negedge clk);
        chk("hold.Sout", 32'(bus.Sout), 32'h000);
        chk("hold.Co",   32'(bus.Co),   32'd1);
        chk("hold.Ovf",  32'(bus.Ovf),  32'd1);

        // Continuous start: accepted at E0, E3, E6; results after E2, E5, E8.
        for (int c = 0; c < 9; c++) begin
            bus.Ain   = cs_a[c];
            bus.Bin   = cs_b[c];
            bus.Ci    = cs_ci[c];
            bus.start = 1'b1;
            if (c % 3 == 0) begin
                exp_t e;
                e.s = cs_s[c]; e.co = cs_co[c]; e.ovf = cs_ov[c];
                e.name = $sformatf("stream%0d", c);
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            if (c == 8) bus.start = 1'b0;
            @(negedge clk);
            chk($sformatf("stream.done_at_E%0d", c), 32'(bus.done), 32'(c % 3 == 2));
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        bus.Ain   = 12'h001;
        bus.Bin   = 12'h001;
        bus.Ci    = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("abort.no_done", 32'(bus.done), 32'd0);
        end
        chk("abort.Sout", 32'(bus.Sout), 32'd0);
        chk("abort.Co",   32'(bus.Co),   32'd0);

        // Reset wins over start on the same edge.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        chk("rst_prio.busy", 32'(bus.busy), 32'd0);
        repeat (4) @(negedge clk);

`ifdef SEQ_ADD_SLICES_SUB_EN
        run_op("sub_neg",  12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0, 1'b0);
        run_op("sub_ovf",  12'h800, 12'h001, 1'b1, 1'b1, 12'h7FF, 1'b1, 1'b1);
        run_op("sub0_add", 12'h03F, 12'h001, 1'b0, 1'b0, 12'h040, 1'b0, 1'b0);
`endif

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
